// File: rtl/branch_ctrl_if.sv
// Control-flow bus between the decode/datapath side and branch_ctrl.
//   master : drives the decoded instruction (pc_in, instr_valid, op, target, zero_flag)
//            and observes the PC controls and stack status.
//   slave  : branch_ctrl itself; consumes the instruction and drives jump_en,
//            jump_line_num, hold, squash, sp, stack_ovf, stack_unf.
interface branch_ctrl_if #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DEPTH  = 4
);
   localparam int unsigned SP_W = $clog2(DEPTH) + 1;

   logic [ADDR_W-1:0] pc_in;
   logic              instr_valid;
   logic [2:0]        op;
   logic [ADDR_W-1:0] target;
   logic              zero_flag;

   logic              jump_en;
   logic [ADDR_W-1:0] jump_line_num;
   logic              hold;
   logic              squash;
   logic [SP_W-1:0]   sp;
   logic              stack_ovf;
   logic              stack_unf;

   modport master (
      output pc_in, instr_valid, op, target, zero_flag,
      input  jump_en, jump_line_num, hold, squash, sp, stack_ovf, stack_unf
   );

   modport slave (
      input  pc_in, instr_valid, op, target, zero_flag,
      output jump_en, jump_line_num, hold, squash, sp, stack_ovf, stack_unf
   );
endinterface

// File: rtl/branch_ctrl.sv
// Control-flow requester for the 8-bit core: resolves JMP/JZ/JNZ/CALL/RET,
// keeps a return-address stack, strobes a one-cycle redirect to the PC,
// squashes the following wrong-path slot and halts on stack faults.
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : branch_ctrl_if slave (instruction in, PC controls/stack status out)
// All outputs are registered.
module branch_ctrl #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DEPTH  = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   branch_ctrl_if.slave bus
);
   localparam int unsigned SP_W  = $clog2(DEPTH) + 1;
   localparam int unsigned PTR_W = $clog2(DEPTH);

   localparam logic [1:0] ST_RUN    = 2'd0;
   localparam logic [1:0] ST_REDIR  = 2'd1;
   localparam logic [1:0] ST_SQUASH = 2'd2;
   localparam logic [1:0] ST_HALT   = 2'd3;

   localparam logic [2:0] OP_JMP  = 3'd1;
   localparam logic [2:0] OP_JZ   = 3'd2;
   localparam logic [2:0] OP_JNZ  = 3'd3;
   localparam logic [2:0] OP_CALL = 3'd4;
   localparam logic [2:0] OP_RET  = 3'd5;

   logic [1:0]        state, state_d;
   logic              jump_en_q, jump_en_d;
   logic [ADDR_W-1:0] jump_addr_q, jump_addr_d;
   logic              hold_q, hold_d;
   logic              squash_q, squash_d;
   logic [SP_W-1:0]   sp_q, sp_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;

   logic [ADDR_W-1:0] stack [DEPTH];
   logic              push_en;
   logic [ADDR_W-1:0] push_data;
   logic [PTR_W-1:0]  push_idx;
   logic [PTR_W-1:0]  pop_idx;
   logic              full;
   logic              empty;
   logic              redirect;
   logic [ADDR_W-1:0] redir_addr;

   assign full     = (sp_q == SP_W'(DEPTH));
   assign empty    = (sp_q == '0);
   assign push_idx = PTR_W'(sp_q);
   assign pop_idx  = PTR_W'(sp_q - SP_W'(1));

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_RUN;
         jump_en_q   <= 1'b0;
         jump_addr_q <= '0;
         hold_q      <= 1'b0;
         squash_q    <= 1'b0;
         sp_q        <= '0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
      end else begin
         state       <= state_d;
         jump_en_q   <= jump_en_d;
         jump_addr_q <= jump_addr_d;
         hold_q      <= hold_d;
         squash_q    <= squash_d;
         sp_q        <= sp_d;
         ovf_q       <= ovf_d;
         unf_q       <= unf_d;
      end
   end

   // Return-address storage; contents are don't-care after reset
   always_ff @(posedge clk) begin
      if (push_en) begin
         stack[push_idx] <= push_data;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d     = state;
      jump_en_d   = 1'b0;
      jump_addr_d = jump_addr_q;
      hold_d      = 1'b0;
      squash_d    = 1'b0;
      sp_d        = sp_q;
      ovf_d       = ovf_q;
      unf_d       = unf_q;
      push_en     = 1'b0;
      push_data   = bus.pc_in + ADDR_W'(1);
      redirect    = 1'b0;
      redir_addr  = bus.target;

      case (state)
         ST_RUN: begin
            if (bus.instr_valid) begin
               case (bus.op)
                  OP_JMP: redirect = 1'b1;
                  OP_JZ:  redirect = bus.zero_flag;
                  OP_JNZ: redirect = !bus.zero_flag;
                  OP_CALL: begin
                     if (full) begin
                        ovf_d   = 1'b1;
                        hold_d  = 1'b1;
                        state_d = ST_HALT;
                     end else begin
                        push_en  = 1'b1;
                        sp_d     = sp_q + SP_W'(1);
                        redirect = 1'b1;
                     end
                  end
                  OP_RET: begin
                     if (empty) begin
                        unf_d   = 1'b1;
                        hold_d  = 1'b1;
                        state_d = ST_HALT;
                     end else begin
                        sp_d       = sp_q - SP_W'(1);
                        redir_addr = stack[pop_idx];
                        redirect   = 1'b1;
                     end
                  end
                  default: redirect = 1'b0;
               endcase
            end
            if (redirect) begin
               state_d     = ST_REDIR;
               jump_en_d   = 1'b1;
               jump_addr_d = redir_addr;
            end
         end
         // The slot after the redirect strobe is the wrong-path fetch
         ST_REDIR: begin
            state_d  = ST_SQUASH;
            squash_d = 1'b1;
         end
         ST_SQUASH: begin
            state_d = ST_RUN;
         end
         ST_HALT: begin
            hold_d = 1'b1;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   assign bus.jump_en       = jump_en_q;
   assign bus.jump_line_num = jump_addr_q;
   assign bus.hold          = hold_q;
   assign bus.squash        = squash_q;
   assign bus.sp            = sp_q;
   assign bus.stack_ovf     = ovf_q;
   assign bus.stack_unf     = unf_q;
endmodule
